// File: rtl/vec_issue_bridge_if.sv
// Bundled CVXIF issue/register/result handshake plus the vector-unit push port.
// The slave modport is the bridge's view of the bundle, and the master modport is the core/vector-unit side.
interface vec_issue_bridge_if #(
  parameter int XLEN     = 32,
  parameter int ID_WIDTH = 4
);
  logic                issue_valid_i;
  logic [31:0]         issue_instr_i;
  logic [ID_WIDTH-1:0] issue_id_i;
  logic                issue_ready_o;
  logic                issue_accept_o;

  logic                reg_valid_i;
  logic [ID_WIDTH-1:0] reg_id_i;
  logic [XLEN-1:0]     reg_rs0_i;
  logic [XLEN-1:0]     reg_rs1_i;
  logic                reg_ready_o;

  logic                vec_valid_o;
  logic [31:0]         vec_instr_o;
  logic [XLEN-1:0]     vec_rs0_o;
  logic [XLEN-1:0]     vec_rs1_o;
  logic                vec_full_i;
  logic                flush_i;

  logic                result_valid_o;
  logic [ID_WIDTH-1:0] result_id_o;
  logic                result_ready_i;
  logic [15:0]         dispatch_cnt_o;

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i,
    output issue_ready_o, issue_accept_o,
    input  reg_valid_i, reg_id_i, reg_rs0_i, reg_rs1_i,
    output reg_ready_o,
    output vec_valid_o, vec_instr_o, vec_rs0_o, vec_rs1_o,
    input  vec_full_i, flush_i,
    output result_valid_o, result_id_o,
    input  result_ready_i,
    output dispatch_cnt_o
  );

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i,
    input  issue_ready_o, issue_accept_o,
    output reg_valid_i, reg_id_i, reg_rs0_i, reg_rs1_i,
    input  reg_ready_o,
    input  vec_valid_o, vec_instr_o, vec_rs0_o, vec_rs1_o,
    output vec_full_i, flush_i,
    input  result_valid_o, result_id_o,
    output result_ready_i,
    input  dispatch_cnt_o
  );
endinterface

// File: rtl/vec_issue_bridge.sv
// Single-entry bridge that takes CVXIF-offloaded vector instructions, collects their scalar operands,
// pushes each one to the vector unit and reports its completion back to the core.
module vec_issue_bridge #(
  parameter int XLEN     = 32,
  parameter int ID_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  vec_issue_bridge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT_REG, DISPATCH, RESP} state_t;

  localparam logic [6:0] OPC_OP_V     = 7'b1010111;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;

  state_t              state;
  logic [31:0]         instr_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [XLEN-1:0]     rs0_q;
  logic [XLEN-1:0]     rs1_q;
  logic [15:0]         dispatch_cnt_q;

  logic [6:0] opcode;
  logic       is_vec;
  logic       needs_ops;
  logic       issue_take;
  logic       reg_hit;
  logic       dispatch_fire;

  assign opcode = bus.issue_instr_i[6:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_vec    = 1'b0;
    needs_ops = 1'b0;
    unique case (opcode)
      OPC_OP_V: begin
        is_vec    = 1'b1;
        needs_ops = bus.issue_instr_i[14];  // funct3 1xx carries scalar operands
      end
      OPC_LOAD_FP, OPC_STORE_FP: begin
        is_vec    = 1'b1;
        needs_ops = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset is synchronous, but all outputs must already be zero during the cycle in which it is
  // asserted, so each output is gated directly by rst.
  assign bus.issue_ready_o  = ~rst & (state == IDLE);
  assign issue_take         = bus.issue_ready_o & bus.issue_valid_i & is_vec;
  assign bus.issue_accept_o = issue_take;
  assign bus.reg_ready_o    = ~rst & (state == WAIT_REG);
  assign reg_hit            = bus.reg_ready_o & bus.reg_valid_i & (bus.reg_id_i == id_q);
  assign dispatch_fire      = ~rst & (state == DISPATCH) & ~bus.vec_full_i & ~bus.flush_i;
  assign bus.vec_valid_o    = dispatch_fire;
  assign bus.result_valid_o = ~rst & (state == RESP);

  assign bus.vec_instr_o    = rst ? '0 : instr_q;
  assign bus.vec_rs0_o      = rst ? '0 : rs0_q;
  assign bus.vec_rs1_o      = rst ? '0 : rs1_q;
  assign bus.result_id_o    = rst ? '0 : id_q;
  assign bus.dispatch_cnt_o = rst ? '0 : dispatch_cnt_q;

  // NOTE: sequential state is updated only with non-blocking assignments, so every read in this block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      instr_q        <= '0;
      id_q           <= '0;
      rs0_q          <= '0;
      rs1_q          <= '0;
      dispatch_cnt_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue_take) begin
            instr_q <= bus.issue_instr_i;
            id_q    <= bus.issue_id_i;
            rs0_q   <= '0;
            rs1_q   <= '0;
            state   <= needs_ops ? WAIT_REG : DISPATCH;
          end
        end
        WAIT_REG: begin
          if (bus.flush_i) begin
            state <= IDLE;
          end else if (reg_hit) begin
            rs0_q <= bus.reg_rs0_i;
            rs1_q <= bus.reg_rs1_i;
            state <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (bus.flush_i) begin
            state <= IDLE;
          end else if (dispatch_fire) begin
            dispatch_cnt_q <= dispatch_cnt_q + 16'd1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (bus.result_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
